ysyx_23060020_mem_arbiter: RTL and testbench
============================================

Name: ysyx_23060020_mem_arbiter

Overview:
Shares the single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write with byte mask). It is needed once the core moves from single-cycle to multi-cycle fetch/execute. It sits between the IFU/LSU and the memory slave, owns the bus for one outstanding transaction at a time, and routes the response back to the requester.

Parameters:
AW, 32, address width
DW, 32, data width
MW, 4, write byte-mask width (DW/8)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
ifu_valid  in  1  IFU request valid; held with ifu_addr until ifu_ready
ifu_addr  in  AW  IFU fetch address
ifu_ready  out  1  IFU request accepted by slave this cycle
ifu_rvalid  out  1  IFU response valid, one cycle
ifu_rdata  out  DW  IFU response data; 0 unless ifu_rvalid
lsu_valid  in  1  LSU request valid; held with all lsu_* fields until lsu_ready
lsu_addr  in  AW  LSU address
lsu_wen  in  1  1=write, 0=read
lsu_wdata  in  DW  LSU write data
lsu_wmask  in  MW  LSU byte mask
lsu_ready  out  1  LSU request accepted by slave this cycle
lsu_rvalid  out  1  LSU response (read data or write ack), one cycle
lsu_rdata  out  DW  LSU read data; 0 unless lsu_rvalid
s_valid  out  1  slave request valid
s_addr  out  AW  slave address
s_wen  out  1  slave write enable; 0 for IFU owner
s_wdata  out  DW  slave write data; 0 for IFU owner
s_wmask  out  MW  slave mask; 0 for IFU owner
s_ready  in  1  slave accepts request
s_rvalid  in  1  slave response valid; never earlier than the cycle after s_valid&s_ready
s_rdata  in  DW  slave read data
err  out  1  sticky protocol error flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, owner=IFU, err=0. All ready/rvalid/s_valid/s_wen/s_wmask outputs are 0; data outputs are 0.
- IDLE: if any valid, register the owner via the pick rule and go to REQ. No output is asserted in IDLE.
- Pick rule, fixed priority: LSU over IFU.
- REQ: s_valid=1, and s_* are muxed combinationally from the owner's inputs. ready to the owner = s_ready, and the other master's ready = 0. When s_ready=1, go to RESP.
- RESP: s_valid=0. When s_rvalid=1, pulse owner_rvalid for one cycle with rdata = s_rdata, then go to IDLE.
- A non-owner valid waits. It is sampled next in IDLE; there is no preemption.
- Latency: minimum 3 cycles from master valid to rvalid (IDLE→REQ, REQ with s_ready=1, RESP with s_rvalid=1). Back-to-back transactions have 1 IDLE cycle between them.
- s_rvalid in IDLE or REQ sets err=1 (sticky until reset). The response is dropped and the state is unchanged.
- Owner dropping valid while in REQ is a master violation. The arbiter keeps s_valid=1 with the held owner until s_ready; no err is raised.
- Reset mid-transaction: return to IDLE immediately. Any outstanding response is lost, and the slave is reset by the same rst.

Optional Feature:
ARB_RR_EN
- Defined: round-robin arbitration using a last_grant register, reset to LSU. When both masters are valid in IDLE, grant the master not granted last. last_grant updates on every grant.
- Undefined: fixed LSU priority, and no last_grant register exists.

Decomposition:
- Package ysyx_23060020_arb_pkg holds the state enum (IDLE, REQ, RESP) and the owner encoding (OWN_IFU=1'b0, OWN_LSU=1'b1).
- One sub-module, ysyx_23060020_arb_pick: combinational pick from ifu_valid, lsu_valid and last_grant (the last_grant input is used only under ARB_RR_EN).

Test Plan:
- Scenario 1, IFU read alone: ifu_valid=1, ifu_addr=0x80000000, s_ready=1, s_rvalid the next cycle with s_rdata=0x00100073 → ifu_ready pulses in REQ, ifu_rvalid=1 with ifu_rdata=0x00100073 at cycle 3, lsu_* outputs stay 0.
- Scenario 2, contention without ARB_RR_EN: both valid, LSU write 0x80001000 with wdata=0xDEADBEEF and wmask=4'b0011 → LSU served first with s_wen=1 and s_wmask=0011, IFU served on the next grant.
- Scenario 3, contention with ARB_RR_EN: both valid continuously for 4 transactions → grant order IFU, LSU, IFU, LSU.
- Scenario 4, slave backpressure: s_ready=0 for 5 cycles in REQ → s_valid and s_addr held stable, no ready pulse, accepted on the 6th cycle.
- Scenario 5, spurious response: s_rvalid=1 while IDLE → err=1, and it stays 1 through later good transactions until rst=0.
- Scenario 6, reset in RESP: rst=0 for 1 cycle while awaiting s_rvalid → state IDLE, all outputs 0, no rvalid delivered, and a new request completes normally afterwards.

Source files
------------

// File: rtl/ysyx_23060020_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states and owner encoding.
package ysyx_23060020_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060020_arb_pick.sv
// Combinational grant selection between IFU and LSU.
// With ARB_RR_EN defined, contention alternates using last_grant; otherwise LSU wins.
module ysyx_23060020_arb_pick
  import ysyx_23060020_arb_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last_grant,
  output logic any_valid,
  output logic grant
);

  // Grant decision for the next transaction
  always_comb begin
    any_valid = ifu_valid | lsu_valid;
`ifdef ARB_RR_EN
    if (ifu_valid && lsu_valid) begin
      grant = ~last_grant;
    end else if (lsu_valid) begin
      grant = OWN_LSU;
    end else begin
      grant = OWN_IFU;
    end
`else
    if (lsu_valid) begin
      grant = OWN_LSU;
    end else begin
      grant = OWN_IFU;
    end
`endif
  end

`ifndef ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/ysyx_23060020_mem_arbiter.sv
// Single-outstanding memory port arbiter between IFU (read-only) and LSU.
// Optional round-robin arbitration is enabled by defining ARB_RR_EN.
module ysyx_23060020_mem_arbiter
  import ysyx_23060020_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_valid,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_ready,
  output logic          ifu_rvalid,
  output logic [DW-1:0] ifu_rdata,
  input  logic          lsu_valid,
  input  logic [AW-1:0] lsu_addr,
  input  logic          lsu_wen,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [MW-1:0] lsu_wmask,
  output logic          lsu_ready,
  output logic          lsu_rvalid,
  output logic [DW-1:0] lsu_rdata,
  output logic          s_valid,
  output logic [AW-1:0] s_addr,
  output logic          s_wen,
  output logic [DW-1:0] s_wdata,
  output logic [MW-1:0] s_wmask,
  input  logic          s_ready,
  input  logic          s_rvalid,
  input  logic [DW-1:0] s_rdata,
  output logic          err
);

  arb_state_e state, state_next;
  logic       owner;
  logic       any_valid;
  logic       grant;
  logic       last_grant;

  ysyx_23060020_arb_pick u_pick (
    .ifu_valid (ifu_valid),
    .lsu_valid (lsu_valid),
    .last_grant(last_grant),
    .any_valid (any_valid),
    .grant     (grant)
  );

  // State, owner and sticky error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= OWN_IFU;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_valid) begin
        owner <= grant;
      end
      // A response outside RESP is a slave protocol violation; it is dropped.
      if (s_rvalid && state != RESP) begin
        err <= 1'b1;
      end
    end
  end

`ifdef ARB_RR_EN
  // Remember who won the last grant for round-robin fairness
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= OWN_LSU;
    end else if (state == IDLE && any_valid) begin
      last_grant <= grant;
    end else begin
      last_grant <= last_grant;
    end
  end
`else
  assign last_grant = OWN_LSU;
`endif

  // Next-state logic; REQ holds until the slave accepts even if the owner drops valid
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = any_valid ? REQ : IDLE;
      REQ:     state_next = s_ready ? RESP : REQ;
      RESP:    state_next = s_rvalid ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end

  // Bus mux and response routing from the registered owner
  always_comb begin
    ifu_ready  = 1'b0;
    ifu_rvalid = 1'b0;
    ifu_rdata  = '0;
    lsu_ready  = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_rdata  = '0;
    s_valid    = 1'b0;
    s_addr     = '0;
    s_wen      = 1'b0;
    s_wdata    = '0;
    s_wmask    = '0;
    case (state)
      REQ: begin
        s_valid = 1'b1;
        if (owner == OWN_LSU) begin
          s_addr    = lsu_addr;
          s_wen     = lsu_wen;
          s_wdata   = lsu_wdata;
          s_wmask   = lsu_wmask;
          lsu_ready = s_ready;
        end else begin
          s_addr    = ifu_addr;
          ifu_ready = s_ready;
        end
      end
      RESP: begin
        if (s_rvalid && owner == OWN_LSU) begin
          lsu_rvalid = 1'b1;
          lsu_rdata  = s_rdata;
        end else if (s_rvalid) begin
          ifu_rvalid = 1'b1;
          ifu_rdata  = s_rdata;
        end else begin
          lsu_rvalid = 1'b0;
        end
      end
      default: s_valid = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060020_mem_arbiter.sv
// Self-checking bench for ysyx_23060020_mem_arbiter: table of transactions plus
// hand-written sequences; expected grant order and data come from a scoreboard.
module tb_ysyx_23060020_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_valid = 1'b0;
  logic [31:0] ifu_addr = 32'h0;
  logic        ifu_ready, ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        lsu_valid = 1'b0;
  logic [31:0] lsu_addr = 32'h0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = 32'h0;
  logic [3:0]  lsu_wmask = 4'h0;
  logic        lsu_ready, lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        s_valid, s_wen;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wmask;
  logic        s_ready = 1'b0;
  logic        s_rvalid = 1'b0;
  logic [31:0] s_rdata = 32'h0;
  logic        err;

  always #5 clk = ~clk;

  ysyx_23060020_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_valid(ifu_valid), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_ready(lsu_ready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wen(s_wen), .s_wdata(s_wdata),
    .s_wmask(s_wmask), .s_ready(s_ready), .s_rvalid(s_rvalid),
    .s_rdata(s_rdata), .err(err)
  );

  typedef struct {
    bit          lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int          ifu_n;
    int          lsu_n;
    logic [31:0] ifu_addr;
    logic [31:0] lsu_addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          delay;
    int          exp_lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   tests = 0;
  int   fails = 0;
  int   ifu_left = 0;
  int   lsu_left = 0;
  int   cur_delay = 0;
  bit   model_last = 1'b1;
  int   lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    logic [31:0] mix;
    mix = 32'hA5A5_5A5A;
    return (a == 32'h8000_0000) ? 32'h0010_0073 : (a ^ mix);
  endfunction

  function automatic bit pick_model(input bit iv, input bit lv, input bit last);
`ifdef ARB_RR_EN
    if (iv && lv) return ~last;
`endif
    return lv;
  endfunction

  // Expected grant sequence for ni IFU and nl LSU requests all pending together
  task automatic push_order(input int ni, input int nl);
    exp_t e;
    bit   w;
    while (ni > 0 || nl > 0) begin
      w = pick_model(ni > 0, nl > 0, model_last);
      model_last = w;
      if (w) begin
        e.lsu = 1'b1; e.addr = lsu_addr; e.wen = lsu_wen;
        e.wdata = lsu_wdata; e.wmask = lsu_wmask; nl--;
      end else begin
        e.lsu = 1'b0; e.addr = ifu_addr; e.wen = 1'b0;
        e.wdata = 32'h0; e.wmask = 4'h0; ni--;
      end
      e.rdata = model_rdata(e.addr);
      sb.push_back(e);
    end
  endtask

  // Slave model + checker; runs until the scoreboard drains or the budget expires
  task automatic run(input int budget, output int first_rv);
    int          cyc;
    int          wait_cnt;
    bit          pend;
    bit          drove_rv;
    logic [31:0] pend_data;
    exp_t        f;
    cyc = 0; wait_cnt = 0; pend = 1'b0; pend_data = 32'h0;
    first_rv = -1;
    while (sb.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      ifu_valid = (ifu_left > 0);
      lsu_valid = (lsu_left > 0);
      s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0; drove_rv = 1'b0;
      if (pend) begin
        s_rvalid = 1'b1; s_rdata = pend_data; drove_rv = 1'b1; pend = 1'b0;
      end
      if (s_valid) s_ready = (wait_cnt >= cur_delay);
      #1;
      f = sb[0];
      if (s_valid && s_ready) begin
        check("s_addr", s_addr, f.addr);
        check("s_wen", {31'h0, s_wen}, {31'h0, f.wen});
        check("s_wdata", s_wdata, f.wdata);
        check("s_wmask", {28'h0, s_wmask}, {28'h0, f.wmask});
        check("owner_ready", {31'h0, (f.lsu ? lsu_ready : ifu_ready)}, 32'h1);
        check("other_ready", {31'h0, (f.lsu ? ifu_ready : lsu_ready)}, 32'h0);
        pend = 1'b1; pend_data = model_rdata(s_addr); wait_cnt = 0;
      end else if (s_valid) begin
        wait_cnt++;
        check("bp_ready", {30'h0, ifu_ready, lsu_ready}, 32'h0);
        check("bp_addr", s_addr, f.addr);
      end
      if (drove_rv) begin
        check("rv_owner", {30'h0, (f.lsu ? {lsu_rvalid, ifu_rvalid} : {ifu_rvalid, lsu_rvalid})}, 32'h2);
        check("rdata", f.lsu ? lsu_rdata : ifu_rdata, f.rdata);
        check("other_rdata", f.lsu ? ifu_rdata : lsu_rdata, 32'h0);
        if (first_rv < 0) first_rv = cyc;
        if (f.lsu) lsu_left--; else ifu_left--;
        void'(sb.pop_front());
      end else begin
        check("no_rv", {30'h0, ifu_rvalid, lsu_rvalid}, 32'h0);
      end
    end
    if (sb.size() > 0) begin
      tests++; fails++;
      $display("FAIL timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    ifu_left = 0; lsu_left = 0;
    @(negedge clk);
    ifu_valid = 1'b0; lsu_valid = 1'b0; s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {26'h0, s_valid, s_wen, ifu_ready, ifu_rvalid, lsu_ready, lsu_rvalid}, 32'h0);
    check({tag, "_saddr"}, s_addr | s_wdata | {28'h0, s_wmask}, 32'h0);
    check({tag, "_rdata"}, ifu_rdata | lsu_rdata, 32'h0);
    check({tag, "_err"}, {31'h0, err}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          ifu_n lsu_n ifu_addr       lsu_addr       wen   wdata          wmask  dly lat
    vecs[0] = '{1, 0, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'h0, 0, 3};
    vecs[1] = '{0, 1, 32'h0000_0000, 32'h8000_0100, 1'b0, 32'h0000_0000, 4'h0, 0, 3};
    vecs[2] = '{1, 1, 32'h8000_0004, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h3, 0, 3};
    vecs[3] = '{0, 1, 32'h0000_0000, 32'h8000_2000, 1'b1, 32'h1234_5678, 4'hF, 2, 5};
    vecs[4] = '{1, 1, 32'h8000_0008, 32'h8000_3000, 1'b0, 32'h0000_0000, 4'h0, 1, 4};
    vecs[5] = '{2, 2, 32'h8000_000C, 32'h8000_4000, 1'b1, 32'hCAFE_F00D, 4'h8, 0, 3};

    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      ifu_addr  = vecs[i].ifu_addr;
      lsu_addr  = vecs[i].lsu_addr;
      lsu_wen   = vecs[i].wen;
      lsu_wdata = vecs[i].wdata;
      lsu_wmask = vecs[i].wmask;
      cur_delay = vecs[i].delay;
      ifu_left  = vecs[i].ifu_n;
      lsu_left  = vecs[i].lsu_n;
      push_order(vecs[i].ifu_n, vecs[i].lsu_n);
      run(200, lat);
      if (vecs[i].exp_lat > 0) check("latency", lat, vecs[i].exp_lat);
    end

    // Slave backpressure for 5 cycles
    lsu_addr = 32'h8000_5000; lsu_wen = 1'b1; lsu_wdata = 32'h0BAD_F00D; lsu_wmask = 4'h6;
    cur_delay = 5; lsu_left = 1;
    push_order(0, 1);
    run(200, lat);
    check("bp_latency", lat, 32'd8);

    // Spurious response while IDLE sets a sticky error
    @(negedge clk);
    s_rvalid = 1'b1; s_rdata = 32'hBAD0_BAD0;
    #1;
    check("spur_rv", {30'h0, ifu_rvalid, lsu_rvalid}, 32'h0);
    check("err_before", {31'h0, err}, 32'h0);
    @(negedge clk);
    s_rvalid = 1'b0; s_rdata = 32'h0;
    #1;
    check("err_set", {31'h0, err}, 32'h1);
    check("spur_state", {31'h0, s_valid}, 32'h0);
    ifu_addr = 32'h8000_0000; cur_delay = 0; ifu_left = 1;
    push_order(1, 0);
    run(200, lat);
    check("spur_latency", lat, 32'd3);
    check("err_sticky", {31'h0, err}, 32'h1);

    // Reset while waiting in RESP
    ifu_addr = 32'h8000_0010;
    @(negedge clk);
    ifu_valid = 1'b1;
    @(negedge clk);
    s_ready = 1'b1;
    #1;
    check("rst_req", {31'h0, s_valid}, 32'h1);
    @(negedge clk);
    s_ready = 1'b0; rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1; ifu_valid = 1'b0;
    #1;
    check_all_zero("postrst");
    model_last = 1'b1;
    ifu_addr = 32'h8000_0020; lsu_addr = 32'h8000_6000; lsu_wen = 1'b0;
    lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    ifu_left = 1; lsu_left = 1;
    push_order(1, 1);
    run(200, lat);
    check("post_latency", lat, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
